// File: rtl/cf_i2s_pkg.sv
// Shared constants and state encoding for the CF I2S transmit path.
package cf_i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;

  localparam logic [1:0] CH_LEFT   = 2'b01;
  localparam logic [1:0] CH_RIGHT  = 2'b10;
  localparam logic [1:0] CH_STEREO = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cf_i2s_tx_fifo.sv
// Sample FIFO with first-word fall-through read data, level count and flush.
module cf_i2s_tx_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Flush dominates; full/empty are the registered-level view of the previous cycle.
  assign do_wr = wr & ~full  & ~flush;
  assign do_rd = rd & ~empty & ~flush;
  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cf_i2s_tx.sv
// I2S / left-justified transmitter, clock master: generates sck/ws and shifts FIFO samples onto sdo.
module cf_i2s_tx #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_wr,
  input  logic [DW-1:0] fifo_wdata,
  input  logic          fifo_flush,
  input  logic [AW:0]   fifo_level_threshold,
  output logic [AW:0]   fifo_level,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_level_below,
  output logic          underrun,
  input  logic [7:0]    sck_prescaler,
  input  logic [5:0]    sample_size,
  input  logic          left_justified,
  input  logic [1:0]    channels,
  output logic          ws,
  output logic          sck,
  output logic          sdo
);
  import cf_i2s_pkg::*;

  localparam int CW = $clog2(FRAME_BITS);

  tx_state_e            state, state_nxt;
  logic [7:0]           pre_cnt;
  logic [CW-1:0]        bit_cnt, bit_nxt, pos;
  logic [SLOT_BITS-1:0] shreg, load_word;
  logic [DW-1:0]        fifo_rdata;
  logic [5:0]           size_sat;
  logic                 tick, start, fall, act, slot_start, ch_en, pop, pop_empty;

  function automatic logic [5:0] sat_size(input logic [5:0] s);
    return (s > 6'd32) ? 6'd32 : s;
  endfunction

  // Move sample bit n-1 to the top so the shift register always emits from bit 31.
  function automatic logic [SLOT_BITS-1:0] align_msb(input logic [SLOT_BITS-1:0] w,
                                                     input logic [5:0] n);
    if (n == 6'd0) return '0;
    return w << (6'd32 - n);
  endfunction

  cf_i2s_tx_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (pop),
    .flush (fifo_flush),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_level_below = (fifo_level < fifo_level_threshold);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)  state_nxt = ST_RUN;
      ST_RUN:  if (!en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The start cycle behaves like a fall tick landing on bit_cnt 0.
  assign tick       = (pre_cnt >= sck_prescaler);
  assign start      = (state == ST_IDLE) && en;
  assign fall       = (state == ST_RUN) && en && tick && sck;
  assign act        = start || fall;
  assign bit_nxt    = start ? '0 : bit_cnt + 1'b1;
  assign pos        = left_justified ? bit_nxt : bit_nxt - 1'b1;
  assign slot_start = (pos[CW-2:0] == '0);
  assign ch_en      = pos[CW-1] ? (channels == CH_RIGHT || channels == CH_STEREO)
                                : (channels == CH_LEFT  || channels == CH_STEREO);
  assign pop        = act && ch_en && slot_start;
  assign pop_empty  = pop && (fifo_empty || fifo_flush);
  assign size_sat   = sat_size(sample_size);
  assign load_word  = pop_empty ? '0 : align_msb(fifo_rdata[SLOT_BITS-1:0], size_sat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      sdo      <= 1'b0;
      shreg    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= pop_empty;
      if ((state == ST_RUN) && !en) begin
        pre_cnt <= '0;
        bit_cnt <= '0;
        sck     <= 1'b0;
        ws      <= 1'b0;
        sdo     <= 1'b0;
        shreg   <= '0;
      end else if (act || (state == ST_RUN)) begin
        if (start) begin
          pre_cnt <= '0;
          sck     <= 1'b0;
        end else begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
          if (tick) sck <= ~sck;
        end
        if (act) begin
          bit_cnt <= bit_nxt;
          ws      <= bit_nxt[CW-1];
          if (slot_start) begin
            if (pop) {sdo, shreg} <= {load_word, 1'b0};
            else     {sdo, shreg} <= '0;
          end else begin
            sdo   <= shreg[SLOT_BITS-1];
            shreg <= shreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cf_i2s_tx.sv
// Directed bench for cf_i2s_tx: framing, I2S offset, underrun, FIFO limits, enable and reset.
module tb_cf_i2s_tx;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_wr;
  logic [31:0]   fifo_wdata;
  logic          fifo_flush;
  logic [AW:0]   fifo_level_threshold;
  logic [AW:0]   fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_level_below;
  logic          underrun;
  logic [7:0]    sck_prescaler;
  logic [5:0]    sample_size;
  logic          left_justified;
  logic [1:0]    channels;
  logic          ws;
  logic          sck;
  logic          sdo;

  int checks = 0;
  int errors = 0;
  int urun_total = 0;

  logic [63:0] cap_ws;
  logic [63:0] cap_sdo;
  int          first_rise;
  int          last_period;

  cf_i2s_tx #(.DW(32), .AW(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (en),
    .fifo_wr              (fifo_wr),
    .fifo_wdata           (fifo_wdata),
    .fifo_flush           (fifo_flush),
    .fifo_level_threshold (fifo_level_threshold),
    .fifo_level           (fifo_level),
    .fifo_full            (fifo_full),
    .fifo_empty           (fifo_empty),
    .fifo_level_below     (fifo_level_below),
    .underrun             (underrun),
    .sck_prescaler        (sck_prescaler),
    .sample_size          (sample_size),
    .left_justified       (left_justified),
    .channels             (channels),
    .ws                   (ws),
    .sck                  (sck),
    .sdo                  (sdo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underrun === 1'b1) urun_total++;

  task automatic push(input logic [31:0] w);
    fifo_wr    = 1'b1;
    fifo_wdata = w;
    @(negedge clk);
    fifo_wr    = 1'b0;
  endtask

  task automatic set_cfg(input int p, input int sz, input logic lj, input logic [1:0] ch);
    sck_prescaler  = 8'(p);
    sample_size    = 6'(sz);
    left_justified = lj;
    channels       = ch;
  endtask

  task automatic stop_and_flush();
    en = 1'b0;
    @(negedge clk);
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  // Records ws/sdo at each sck rise; sample k lands in bit n-1-k (first sample is MSB).
  task automatic capture(input int n, input int budget);
    logic prev;
    int   cyc, k, since;
    prev = sck; k = 0; cyc = 0; since = 0;
    first_rise = -1; last_period = -1;
    cap_ws = '0; cap_sdo = '0;
    while (k < n && cyc < budget) begin
      @(negedge clk);
      cyc++; since++;
      if (sck === 1'b1 && prev === 1'b0) begin
        if (k == 0) first_rise = cyc;
        else        last_period = since;
        cap_ws[n-1-k]  = ws;
        cap_sdo[n-1-k] = sdo;
        k++;
        since = 0;
      end
      prev = sck;
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL capture_timeout rises got %0d need %0d", k, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; fifo_wr = 1'b0; fifo_wdata = '0; fifo_flush = 1'b0;
    fifo_level_threshold = '0;
    set_cfg(1, 16, 1'b1, 2'b11);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({sck, ws, sdo} !== 3'b000) begin errors++; $display("FAIL reset_pins got %b need 000", {sck, ws, sdo}); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b need 0", underrun); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d need 0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b need 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b need 0", fifo_full); end
  endtask

  task automatic test_lj_stereo();
    int u0;
    set_cfg(1, 16, 1'b1, 2'b11);
    push(32'h0000ABCD);
    push(32'h00001234);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL lj_level_pre got %0d need 2", fifo_level); end
    u0 = urun_total;
    en = 1'b1;
    capture(64, 400);
    checks++; if (first_rise != 3) begin errors++; $display("FAIL lj_first_rise got %0d need 3", first_rise); end
    checks++; if (last_period != 4) begin errors++; $display("FAIL lj_sck_period got %0d need 4", last_period); end
    checks++; if (cap_ws !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL lj_ws got %h need 00000000ffffffff", cap_ws); end
    checks++; if (cap_sdo !== 64'hABCD_0000_1234_0000) begin errors++; $display("FAIL lj_sdo got %h need abcd000012340000", cap_sdo); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL lj_level_post got %0d need 0", fifo_level); end
    checks++; if (urun_total - u0 != 0) begin errors++; $display("FAIL lj_underrun got %0d need 0", urun_total - u0); end
    stop_and_flush();
  endtask

  task automatic test_i2s_left();
    int u0;
    set_cfg(0, 24, 1'b0, 2'b01);
    push(32'h00800001);
    push(32'h00FFFFFF);
    u0 = urun_total;
    en = 1'b1;
    capture(64, 400);
    checks++; if (cap_ws !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL i2s_ws got %h need 00000000ffffffff", cap_ws); end
    checks++; if (cap_sdo !== 64'h4000_0080_0000_0000) begin errors++; $display("FAIL i2s_sdo got %h need 4000008000000000", cap_sdo); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL i2s_one_pop got %0d need 1", fifo_level); end
    checks++; if (urun_total - u0 != 0) begin errors++; $display("FAIL i2s_underrun got %0d need 0", urun_total - u0); end
    stop_and_flush();
  endtask

  task automatic test_underrun();
    int u0;
    set_cfg(3, 8, 1'b1, 2'b11);
    push(32'h000000A5);
    u0 = urun_total;
    en = 1'b1;
    capture(64, 700);
    checks++; if (cap_sdo !== 64'hA500_0000_0000_0000) begin errors++; $display("FAIL urun_frame1_sdo got %h need a500000000000000", cap_sdo); end
    checks++; if (urun_total - u0 != 1) begin errors++; $display("FAIL urun_pulses got %0d need 1", urun_total - u0); end
    push(32'h00000011);
    push(32'h00000022);
    capture(64, 700);
    checks++; if (cap_sdo !== 64'h1100_0000_2200_0000) begin errors++; $display("FAIL urun_frame2_sdo got %h need 1100000022000000", cap_sdo); end
    checks++; if (cap_ws !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL urun_frame2_ws got %h need 00000000ffffffff", cap_ws); end
    checks++; if (urun_total - u0 != 1) begin errors++; $display("FAIL urun_pulses_after got %0d need 1", urun_total - u0); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL urun_level got %0d need 0", fifo_level); end
    stop_and_flush();
  endtask

  task automatic test_fifo_bounds();
    for (int i = 1; i <= 5; i++) push(32'(i));
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fifo_full_level got %0d need 4", fifo_level); end
    checks++; if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin errors++; $display("FAIL fifo_full_flags got full=%b empty=%b need full=1 empty=0", fifo_full, fifo_empty); end
    fifo_level_threshold = 3'd4;
    #1;
    checks++; if (fifo_level_below !== 1'b0) begin errors++; $display("FAIL fifo_below_full got %b need 0", fifo_level_below); end
    @(negedge clk);
    fifo_flush = 1'b1; fifo_wr = 1'b1; fifo_wdata = 32'h99;
    @(negedge clk);
    fifo_flush = 1'b0; fifo_wr = 1'b0;
    checks++; if (fifo_level !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL fifo_flush_write got level=%0d empty=%b full=%b need 0 1 0", fifo_level, fifo_empty, fifo_full);
    end
    push(32'h7);
    fifo_level_threshold = 3'd2;
    #1;
    checks++; if (fifo_level_below !== 1'b1) begin errors++; $display("FAIL fifo_below_thr2 got %b need 1", fifo_level_below); end
    fifo_level_threshold = 3'd1;
    #1;
    checks++; if (fifo_level_below !== 1'b0) begin errors++; $display("FAIL fifo_below_thr1 got %b need 0", fifo_level_below); end
    fifo_level_threshold = 3'd0;
    stop_and_flush();
  endtask

  task automatic test_en_drop();
    set_cfg(1, 16, 1'b1, 2'b11);
    push(32'h0000FFFF);
    push(32'h00008000);
    en = 1'b1;
    capture(5, 100);
    checks++; if (sdo !== 1'b1 || sck !== 1'b1) begin errors++; $display("FAIL endrop_midslot got sck=%b sdo=%b need 1 1", sck, sdo); end
    en = 1'b0;
    @(negedge clk);
    checks++; if ({sck, ws, sdo} !== 3'b000) begin errors++; $display("FAIL endrop_pins got %b need 000", {sck, ws, sdo}); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL endrop_level got %0d need 1", fifo_level); end
    en = 1'b1;
    capture(16, 200);
    checks++; if (first_rise != 3) begin errors++; $display("FAIL reen_first_rise got %0d need 3", first_rise); end
    checks++; if (cap_sdo[15:0] !== 16'h8000 || cap_ws[15:0] !== 16'h0000) begin
      errors++; $display("FAIL reen_data got sdo=%h ws=%h need 8000 0000", cap_sdo[15:0], cap_ws[15:0]);
    end
    stop_and_flush();
  endtask

  task automatic test_async_reset();
    set_cfg(1, 16, 1'b1, 2'b11);
    push(32'h0000FFFF);
    push(32'h0000FFFF);
    en = 1'b1;
    capture(3, 50);
    checks++; if (sck !== 1'b1 || sdo !== 1'b1 || fifo_level !== 3'd1) begin
      errors++; $display("FAIL arst_pre got sck=%b sdo=%b level=%0d need 1 1 1", sck, sdo, fifo_level);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({sck, ws, sdo, underrun} !== 4'b0000) begin errors++; $display("FAIL arst_pins got %b need 0000", {sck, ws, sdo, underrun}); end
    checks++; if (fifo_level !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL arst_fifo got level=%0d empty=%b full=%b need 0 1 0", fifo_level, fifo_empty, fifo_full);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({sck, ws, sdo} !== 3'b000) begin errors++; $display("FAIL arst_idle got %b need 000", {sck, ws, sdo}); end
  endtask

  initial begin
    test_reset();
    test_lj_stereo();
    test_i2s_left();
    test_underrun();
    test_fifo_bounds();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
